// File: rtl/rom_fetch_initiator.sv
// rom_fetch_initiator: four-byte little-endian fetch over a two-phase trigger/ready ROM; ROM_FETCH_TIMEOUT_EN adds a per-byte wait timeout
module rom_fetch_initiator #(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetchReq,
  input  logic [31:0] fetchAddr,
  output logic        fetchReady,
  output logic [31:0] instrOut,
  output logic        instrValid,
  output logic [31:0] romAddr,
  output logic        romTrigger,
  input  logic [7:0]  romData,
  input  logic        romReady,
  output logic        fetchErr
);
  localparam int MIN_WAIT = SYNC_STAGES + SETTLE_CYCLES;
  localparam int CW       = $clog2(MIN_WAIT + TIMEOUT_CYCLES + 2);

  typedef enum logic [2:0] {IDLE, SETUP, TOGGLE, WAIT, CAPTURE, DONE} state_t;

  state_t                 state, state_n;
  logic [31:0]            base;
  logic [23:0]            word;
  logic [1:0]             idx;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rdy_s, go, tmo;

  assign rdy_s      = sync[SYNC_STAGES-1];
  assign go         = (cnt >= CW'(MIN_WAIT)) && rdy_s;
  assign fetchReady = (state == IDLE);

`ifdef ROM_FETCH_TIMEOUT_EN
  assign tmo = !go && (cnt >= CW'(TIMEOUT_CYCLES));
`else
  assign tmo = 1'b0;
`endif

  // bring the asynchronous ready level into the clock domain
  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], romReady};
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // sequencing: one SETUP/TOGGLE/WAIT/CAPTURE pass per byte, then DONE
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = fetchReq ? SETUP : IDLE;
      SETUP:   state_n = TOGGLE;
      TOGGLE:  state_n = WAIT;
      WAIT:    state_n = go ? CAPTURE : (tmo ? IDLE : WAIT);
      CAPTURE: state_n = (idx == 2'd3) ? DONE : SETUP;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // datapath: address, trigger, settle counter and word assembly
  always_ff @(posedge clk) begin
    if (reset) begin
      base       <= '0;
      word       <= '0;
      idx        <= '0;
      cnt        <= '0;
      romAddr    <= '0;
      romTrigger <= 1'b0;
      instrOut   <= '0;
      instrValid <= 1'b0;
      fetchErr   <= 1'b0;
    end else begin
      instrValid <= 1'b0;
      fetchErr   <= 1'b0;
      if (state == IDLE && fetchReq) begin
        base <= fetchAddr;
        idx  <= '0;
      end
      if (state == SETUP) begin
        romAddr <= base + {30'd0, idx};
        cnt     <= '0;
      end
      if (state == TOGGLE) romTrigger <= ~romTrigger;
      if ((state == TOGGLE || state == WAIT) && !(&cnt)) cnt <= cnt + 1'b1;
      if (state == WAIT) fetchErr <= tmo;
      if (state == CAPTURE) begin
        word <= {romData, word[23:8]};
        idx  <= idx + 2'd1;
      end
      if (state == CAPTURE && idx == 2'd3) begin
        instrOut   <= {romData, word};
        instrValid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rom_fetch_initiator.sv
// tb_rom_fetch_initiator: randomized fetches against a byte-array ROM model with stall injection
module tb_rom_fetch_initiator;
  localparam int SYNC     = 2;
  localparam int SETTLE   = 2;
  localparam int BYTE_LAT = 2 + SYNC + SETTLE + 1;
  localparam int VAL_LAT  = 4 * BYTE_LAT + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetchReq = 1'b0;
  logic [31:0] fetchAddr = '0;
  logic        fetchReady, instrValid, romTrigger, fetchErr;
  logic [31:0] instrOut, romAddr;
  logic [7:0]  romData = '0;
  logic        romReady = 1'b1;

  logic [7:0]  mem [0:255];
  logic [31:0] addr_log [$];
  logic        trig_q = 1'b0;
  int          low_left = 0;
  int          stall_byte = -1;
  int          stall_len = 0;
  int          cyc = 0;
  int          last_tog = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  rom_fetch_initiator #(.SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .fetchReq(fetchReq), .fetchAddr(fetchAddr),
    .fetchReady(fetchReady), .instrOut(instrOut), .instrValid(instrValid),
    .romAddr(romAddr), .romTrigger(romTrigger), .romData(romData),
    .romReady(romReady), .fetchErr(fetchErr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // ROM responder: every trigger edge requests one byte; a selected byte drops ready for stall_len cycles
  always @(negedge clk) begin
    if (stall_len == 0 && low_left > 0) begin
      low_left = 0;
      romReady = 1'b1;
    end
    if (romTrigger !== trig_q) begin
      trig_q = romTrigger;
      addr_log.push_back(romAddr);
      last_tog = cyc;
      if (stall_len > 0 && addr_log.size() == stall_byte + 1) begin
        romReady = 1'b0;
        low_left = stall_len;
      end
    end else if (low_left > 0) begin
      low_left--;
      if (low_left == 0) romReady = 1'b1;
    end
    romData = romReady ? mem[romAddr[7:0]] : 8'hEE;
  end

  // one fetch: a ready drop of L cycles adds max(0, L+SYNC-(SYNC+SETTLE-1)) cycles to that byte
  task automatic run_fetch(input logic [31:0] a, input int sb, input int sl, input bit poke, input string nm);
    logic [31:0] exp, t;
    int vk, rk, pulses, extra;
    bit err, ready1, aok;
    exp = '0;
    for (int i = 0; i < 4; i++) begin
      t = a + i;
      exp[8*i +: 8] = mem[t[7:0]];
    end
    extra = (sl > 0) ? sl + SYNC - (SYNC + SETTLE - 1) : 0;
    if (extra < 0) extra = 0;
    stall_byte = sb;
    stall_len = sl;
    @(negedge clk);
    total++;
    if (fetchReady !== 1'b1) begin bad++; $display("FAIL %s ready_before got=%b want=1", nm, fetchReady); end
    addr_log.delete();
    fetchReq = 1'b1;
    fetchAddr = a;
    vk = 0; rk = 0; pulses = 0; err = 1'b0; ready1 = 1'b1;
    for (int k = 1; k <= 200 && rk == 0; k++) begin
      @(negedge clk);
      fetchReq = (poke && k >= 3 && k <= 20) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (poke) fetchAddr = $urandom;
      if (k == 1) ready1 = fetchReady;
      if (instrValid === 1'b1) begin pulses++; if (vk == 0) vk = k; end
      if (fetchErr !== 1'b0) err = 1'b1;
      if (k > 1 && fetchReady === 1'b1) rk = k;
    end
    fetchReq = 1'b0;
    total++;
    if (ready1 !== 1'b0) begin bad++; $display("FAIL %s ready_drop got=%b want=0", nm, ready1); end
    total++;
    if (vk != VAL_LAT + extra) begin bad++; $display("FAIL %s valid_latency got=%0d want=%0d", nm, vk, VAL_LAT + extra); end
    total++;
    if (rk != VAL_LAT + 1 + extra) begin bad++; $display("FAIL %s ready_latency got=%0d want=%0d", nm, rk, VAL_LAT + 1 + extra); end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL %s valid_pulses got=%0d want=1", nm, pulses); end
    total++;
    if (instrOut !== exp) begin bad++; $display("FAIL %s word got=%h want=%h", nm, instrOut, exp); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL %s fetchErr got=1 want=0", nm); end
    aok = (addr_log.size() == 4);
    for (int i = 0; i < 4 && aok; i++) if (addr_log[i] !== a + i) aok = 1'b0;
    total++;
    if (!aok) begin
      bad++;
      $display("FAIL %s addr_seq got=%0d toggles first=%h want=4 toggles from %h", nm, addr_log.size(),
               (addr_log.size() > 0) ? addr_log[0] : 32'hx, a);
    end
    stall_len = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (romTrigger !== 1'b0) begin bad++; $display("FAIL reset romTrigger got=%b want=0", romTrigger); end
    total++;
    if (romAddr !== 32'd0) begin bad++; $display("FAIL reset romAddr got=%h want=0", romAddr); end
    total++;
    if (instrOut !== 32'd0) begin bad++; $display("FAIL reset instrOut got=%h want=0", instrOut); end
    total++;
    if (instrValid !== 1'b0) begin bad++; $display("FAIL reset instrValid got=%b want=0", instrValid); end
    total++;
    if (fetchErr !== 1'b0) begin bad++; $display("FAIL reset fetchErr got=%b want=0", fetchErr); end
    total++;
    if (fetchReady !== 1'b1) begin bad++; $display("FAIL reset fetchReady got=%b want=1", fetchReady); end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (fetchReady !== 1'b1 || romTrigger !== 1'b0) begin
      bad++; $display("FAIL reset_release ready/trig got=%b%b want=10", fetchReady, romTrigger);
    end
  endtask

  task automatic test_reset_with_req;
    @(negedge clk);
    reset = 1'b1;
    fetchReq = 1'b1;
    fetchAddr = 32'h100;
    @(negedge clk);
    reset = 1'b0;
    fetchReq = 1'b0;
    @(negedge clk);
    total++;
    if (fetchReady !== 1'b1 || romAddr !== 32'd0) begin
      bad++; $display("FAIL reset_wins ready=%b addr=%h want ready=1 addr=0", fetchReady, romAddr);
    end
  endtask

  task automatic test_reset_midop;
    int pulses, k;
    stall_len = 0;
    @(negedge clk);
    addr_log.delete();
    fetchReq = 1'b1;
    fetchAddr = 32'h0;
    @(negedge clk);
    fetchReq = 1'b0;
    k = 0;
    while (addr_log.size() < 2 && k < 50) begin @(negedge clk); k++; end
    total++;
    if (addr_log.size() < 2) begin bad++; $display("FAIL midop_reach_byte1 got=%0d toggles want=2", addr_log.size()); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (romTrigger !== 1'b0) begin bad++; $display("FAIL midop romTrigger got=%b want=0", romTrigger); end
    total++;
    if (instrOut !== 32'd0) begin bad++; $display("FAIL midop instrOut got=%h want=0", instrOut); end
    total++;
    if (fetchReady !== 1'b1) begin bad++; $display("FAIL midop fetchReady got=%b want=1", fetchReady); end
    pulses = 0;
    repeat (40) begin @(negedge clk); if (instrValid !== 1'b0) pulses++; end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL midop no_valid got=%0d want=0", pulses); end
    run_fetch(32'h4, -1, 0, 1'b0, "after_reset");
    total++;
    if (instrOut !== 32'hDDCCBBAA) begin bad++; $display("FAIL after_reset_word got=%h want=DDCCBBAA", instrOut); end
  endtask

  task automatic test_stuck_rom;
    logic [31:0] prev;
    int hi, errs, ek;
    prev = instrOut;
    stall_byte = 0;
    stall_len = 100000;
    @(negedge clk);
    addr_log.delete();
    fetchReq = 1'b1;
    fetchAddr = 32'h40;
    @(negedge clk);
    fetchReq = 1'b0;
`ifdef ROM_FETCH_TIMEOUT_EN
    ek = 0;
    for (int k = 0; k < 300 && ek == 0; k++) begin @(negedge clk); if (fetchErr === 1'b1) ek = cyc; end
    total++;
    if (ek - last_tog != 64) begin bad++; $display("FAIL timeout_at got=%0d want=64", ek - last_tog); end
    total++;
    if (fetchReady !== 1'b1 || instrOut !== prev) begin
      bad++; $display("FAIL timeout_state ready=%b word=%h want ready=1 word=%h", fetchReady, instrOut, prev);
    end
    hi = 0; errs = 0;
`else
    hi = 0; errs = 0; ek = 0;
    repeat (500) begin
      @(negedge clk);
      if (fetchReady !== 1'b0) hi++;
      if (fetchErr !== 1'b0) errs++;
    end
    total++;
    if (hi != 0) begin bad++; $display("FAIL stuck_ready got=%0d cycles high want=0", hi); end
    total++;
    if (errs != 0) begin bad++; $display("FAIL stuck_err got=%0d pulses want=0", errs); end
    total++;
    if (instrOut !== prev) begin bad++; $display("FAIL stuck_word got=%h want=%h", instrOut, prev); end
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stall_len = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] a, t;
    int sb, sl;
    for (int n = 0; n < 8; n++) begin
      a = $urandom;
      for (int i = 0; i < 4; i++) begin
        t = a + i;
        mem[t[7:0]] = 8'($urandom);
      end
      sb = $urandom_range(0, 3);
      sl = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
      run_fetch(a, sb, sl, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h78; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;
    mem[4] = 8'hAA; mem[5] = 8'hBB; mem[6] = 8'hCC; mem[7] = 8'hDD;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22;
    test_reset();
    run_fetch(32'h0, -1, 0, 1'b0, "basic");
    total++;
    if (instrOut !== 32'h12345678) begin bad++; $display("FAIL basic_const got=%h want=12345678", instrOut); end
    run_fetch(32'hFFFFFFFE, -1, 0, 1'b0, "wrap");
    total++;
    if (instrOut !== 32'h56782211) begin bad++; $display("FAIL wrap_const got=%h want=56782211", instrOut); end
    run_fetch(32'h20, 2, 11, 1'b1, "slow_rom");
    test_reset_with_req();
    test_reset_midop();
    test_stuck_rom();
    test_random();
    run_fetch(32'h0, -1, 0, 1'b0, "back_to_back_a");
    run_fetch(32'h4, -1, 0, 1'b0, "back_to_back_b");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
